// File: rtl/replica_pkg.sv
// Shared types and fixed-point constants for the replica exchange blocks.
// Formats: Q4.12 for the energy product y, Q0.16 for probabilities,
// Q1.16 for delta_beta, signed Q5.16 for the Taylor accumulator.
package replica_pkg;

    localparam int node_num = 8;

    localparam int DIST_W   = 20;  // tour distance, unsigned integer
    localparam int DBETA_W  = 17;  // Q1.16
    localparam int Q412_W   = 16;  // Q4.12
    localparam int Q016_W   = 16;  // Q0.16
    localparam int RECIP_W  = 17;  // 1/k with one integer bit so 1/1 is exact
    localparam int TERM_W   = 20;  // Q4.16 unsigned Taylor term
    localparam int SUM_W    = 22;  // signed Q5.16 Taylor accumulator
    localparam int SQUARE_STEPS = 3;  // exp(-y) = exp(-y/8)^8

    typedef logic [DIST_W-1:0] distance_t;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        SELF = 2'd1,
        PREV = 2'd2,
        FOLW = 2'd3
    } exchange_command_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        TAYLOR,
        SQUARE,
        CMP
    } judge_state_t;

    // Reciprocal table 1/k, k = 1..8, 16 fractional bits (rounded).
    function automatic logic [RECIP_W-1:0] recip_tab(input logic [3:0] k);
        case (k)
            4'd1:    recip_tab = 17'h10000;
            4'd2:    recip_tab = 17'h08000;
            4'd3:    recip_tab = 17'h05555;
            4'd4:    recip_tab = 17'h04000;
            4'd5:    recip_tab = 17'h03333;
            4'd6:    recip_tab = 17'h02AAB;
            4'd7:    recip_tab = 17'h02492;
            4'd8:    recip_tab = 17'h02000;
            default: recip_tab = '0;
        endcase
    endfunction

endpackage

// File: rtl/exp_neg_unit.sv
// exp(-y) evaluator: z = y/8, Taylor series for exp(-z), then three squarings.
// start is a one-cycle pulse; taylor_last flags the final series cycle and
// done flags the final squaring cycle, during which p carries the result.
module exp_neg_unit
    import replica_pkg::*;
#(
    parameter int taylor_order = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [Q412_W-1:0] y,
    output logic              taylor_last,
    output logic              done,
    output logic [Q016_W-1:0] p
);

    typedef enum logic [1:0] {EXP_IDLE, EXP_TAYLOR, EXP_SQUARE} exp_phase_t;

    exp_phase_t               phase_q, phase_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [Q412_W-1:0]        z_q, z_d;
    logic [TERM_W-1:0]        term_q, term_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [Q016_W-1:0]        p_q, p_d;

    logic [TERM_W-1:0]        tz;
    logic [TERM_W-1:0]        term_next;
    logic signed [SUM_W-1:0]  term_ext;
    logic signed [SUM_W-1:0]  sum_next;
    logic [Q016_W-1:0]        sq;

    // Clamp the signed series sum into a Q0.16 probability.
    function automatic logic [Q016_W-1:0] clamp_q016(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1])
            clamp_q016 = '0;
        else if (|s[SUM_W-2:16])
            clamp_q016 = 16'hFFFF;
        else
            clamp_q016 = s[15:0];
    endfunction

    // Series step, squaring step and phase sequencing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        z_d         = z_q;
        term_d      = term_q;
        sum_d       = sum_q;
        p_d         = p_q;
        taylor_last = 1'b0;
        done        = 1'b0;

        // term_k = term_{k-1} * z / k ; Q4.16 * Q4.12 >> 12, then * Q1.16 >> 16
        tz        = TERM_W'(36'(term_q * z_q) >> 12);
        term_next = TERM_W'(37'(tz * recip_tab(cnt_q)) >> 16);
        term_ext  = $signed({2'b00, term_next});
        sum_next  = cnt_q[0] ? (sum_q - term_ext) : (sum_q + term_ext);
        sq        = Q016_W'(32'(p_q * p_q) >> 16);
        p         = sq;

        unique case (phase_q)
            EXP_IDLE: begin
                if (start) begin
                    z_d     = y >> 3;
                    term_d  = 20'h10000;
                    sum_d   = 22'sh10000;
                    cnt_d   = 4'd1;
                    phase_d = EXP_TAYLOR;
                end
            end
            EXP_TAYLOR: begin
                term_d = term_next;
                sum_d  = sum_next;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(taylor_order)) begin
                    taylor_last = 1'b1;
                    p_d         = clamp_q016(sum_next);
                    cnt_d       = 4'd1;
                    phase_d     = EXP_SQUARE;
                end
            end
            EXP_SQUARE: begin
                p_d   = sq;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SQUARE_STEPS)) begin
                    done    = 1'b1;
                    phase_d = EXP_IDLE;
                end
            end
            default: phase_d = EXP_IDLE;
        endcase
    end

    // Datapath and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= EXP_IDLE;
            cnt_q   <= '0;
            z_q     <= '0;
            term_q  <= '0;
            sum_q   <= '0;
            p_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            term_q  <= term_d;
            sum_q   <= sum_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: rtl/replica_exchange_judge.sv
// Initiator side of the Metropolis replica exchange test with the following
// neighbour. Decision is presented in the CMP cycle (done=1), which also
// behaves like IDLE so a back-to-back test_start is accepted there.
// Optional macro EXCHANGE_STAT_EN adds a saturating accepted-swap counter.
module replica_exchange_judge
    import replica_pkg::*;
#(
    parameter int id           = 0,
    parameter int taylor_order = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              test_start,
    input  logic              parity,
    input  distance_t         self_dist,
    input  distance_t         folw_dist,
    input  logic [DBETA_W-1:0] delta_beta,
    input  logic [Q016_W-1:0] rand_val,
    output logic              busy,
    output logic              done,
    output logic              out_exchange,
    output exchange_command_t exchange_cmd
`ifdef EXCHANGE_STAT_EN
    ,
    input  logic              stat_clear,
    output logic [15:0]       accept_cnt
`endif
);

    localparam int  PROD_W       = DBETA_W + DIST_W;
    localparam logic ID_PARITY   = 1'(id % 2);
    localparam logic PAIRS_FWD   = (id != node_num - 1);

    judge_state_t       state_q, state_d;
    distance_t          self_q, self_d, folw_q, folw_d;
    logic [DBETA_W-1:0] dbeta_q, dbeta_d;
    logic [Q016_W-1:0]  rand_q, rand_d;
    logic               out_exchange_q, out_exchange_d;
    exchange_command_t  exchange_cmd_q, exchange_cmd_d;

    distance_t          d_energy;
    logic [PROD_W-1:0]  prod;
    logic [Q412_W-1:0]  y_mul;
    logic               y_sat;
    logic               participating;
    logic               accept;
    logic               exp_start;
    logic               exp_taylor_last;
    logic               exp_done;
    logic [Q016_W-1:0]  exp_p;

    exp_neg_unit #(
        .taylor_order (taylor_order)
    ) u_exp (
        .clk         (clk),
        .reset       (reset),
        .start       (exp_start),
        .y           (y_mul),
        .taylor_last (exp_taylor_last),
        .done        (exp_done),
        .p           (exp_p)
    );

    // Next-state, input latching and decision logic.
    always_comb begin
        state_d        = state_q;
        self_d         = self_q;
        folw_d         = folw_q;
        dbeta_d        = dbeta_q;
        rand_d         = rand_q;
        out_exchange_d = out_exchange_q;
        exchange_cmd_d = exchange_cmd_q;
        exp_start      = 1'b0;

        participating = PAIRS_FWD && (parity == ID_PARITY);
        // y = delta_beta(Q1.16) * dE, truncated to Q4.12; anything >= 16.0 saturates
        d_energy = self_q - folw_q;
        prod     = PROD_W'(dbeta_q) * PROD_W'(d_energy);
        y_mul    = Q412_W'(prod >> 4);
        y_sat    = (prod >> 20) != '0;
        accept   = rand_q < exp_p;

        unique case (state_q)
            IDLE, CMP: begin
                if (test_start) begin
                    self_d         = self_dist;
                    folw_d         = folw_dist;
                    dbeta_d        = delta_beta;
                    rand_d         = rand_val;
                    out_exchange_d = 1'b0;
                    exchange_cmd_d = NOP;
                    if (!participating) begin
                        exchange_cmd_d = SELF;
                        state_d        = CMP;
                    end else if (folw_dist >= self_dist || delta_beta == '0) begin
                        out_exchange_d = 1'b1;
                        exchange_cmd_d = FOLW;
                        state_d        = CMP;
                    end else begin
                        state_d = MUL;
                    end
                end else if (state_q == CMP) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (y_sat) begin
                    // p = 0: no random value can be below it
                    exchange_cmd_d = SELF;
                    state_d        = CMP;
                end else begin
                    exp_start = 1'b1;
                    state_d   = TAYLOR;
                end
            end
            TAYLOR: begin
                if (exp_taylor_last)
                    state_d = SQUARE;
            end
            SQUARE: begin
                if (exp_done) begin
                    out_exchange_d = accept;
                    exchange_cmd_d = accept ? FOLW : SELF;
                    state_d        = CMP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched operands and held decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            self_q         <= '0;
            folw_q         <= '0;
            dbeta_q        <= '0;
            rand_q         <= '0;
            out_exchange_q <= 1'b0;
            exchange_cmd_q <= NOP;
        end else begin
            state_q        <= state_d;
            self_q         <= self_d;
            folw_q         <= folw_d;
            dbeta_q        <= dbeta_d;
            rand_q         <= rand_d;
            out_exchange_q <= out_exchange_d;
            exchange_cmd_q <= exchange_cmd_d;
        end
    end

    assign busy         = (state_q == MUL) || (state_q == TAYLOR) || (state_q == SQUARE);
    assign done         = (state_q == CMP);
    assign out_exchange = out_exchange_q;
    assign exchange_cmd = exchange_cmd_q;

`ifdef EXCHANGE_STAT_EN
    logic [15:0] accept_cnt_q, accept_cnt_d;
    logic        accept_evt;

    // Saturating count of accepted swaps; clear beats a same-cycle increment.
    always_comb begin
        accept_evt   = (state_d == CMP) && out_exchange_d;
        accept_cnt_d = accept_cnt_q;
        if (stat_clear)
            accept_cnt_d = '0;
        else if (accept_evt && accept_cnt_q != 16'hFFFF)
            accept_cnt_d = accept_cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            accept_cnt_q <= '0;
        else
            accept_cnt_q <= accept_cnt_d;
    end

    assign accept_cnt = accept_cnt_q;
`endif

endmodule

// File: tb/tb_replica_exchange_judge.sv
// Scoreboard bench for replica_exchange_judge (id=0). Expected decisions come
// from a real-valued exp() reference; the monitor pops them when done fires.
`timescale 1ns/1ps
module tb_replica_exchange_judge;
    import replica_pkg::*;

    localparam int TAYLOR_N = 6;
    localparam int FULL_LAT = 1 + TAYLOR_N + 3 + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              test_start;
    logic              parity;
    distance_t         self_dist, folw_dist;
    logic [16:0]       delta_beta;
    logic [15:0]       rand_val;
    logic              busy, done, out_exchange;
    exchange_command_t exchange_cmd;
`ifdef EXCHANGE_STAT_EN
    logic              stat_clear;
    logic [15:0]       accept_cnt;
`endif

    typedef struct {
        logic              exch;
        exchange_command_t cmd;
        int                start;
        int                lat;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   model_cnt = 0;
    bit   mon_en    = 1'b0;

    replica_exchange_judge #(
        .id           (0),
        .taylor_order (TAYLOR_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .test_start   (test_start),
        .parity       (parity),
        .self_dist    (self_dist),
        .folw_dist    (folw_dist),
        .delta_beta   (delta_beta),
        .rand_val     (rand_val),
        .busy         (busy),
        .done         (done),
        .out_exchange (out_exchange),
        .exchange_cmd (exchange_cmd)
`ifdef EXCHANGE_STAT_EN
        ,
        .stat_clear   (stat_clear),
        .accept_cnt   (accept_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference p = exp(-8*z) * 2^16 with z = (y >> 3) in Q4.12.
    function automatic real p_ref_of(input logic [16:0] db, input longint de);
        longint prod;
        longint z;
        prod = longint'(db) * de;
        z    = (prod >> 4) >> 3;
        return $exp(-(8.0 * real'(z)) / 4096.0) * 65536.0;
    endfunction

    function automatic void expect_of(input distance_t s, input distance_t f,
                                      input logic [16:0] db, input logic [15:0] r,
                                      input logic par, output logic ex, output int lat);
        longint prod;
        if (par != 1'b0) begin
            ex = 1'b0; lat = 1;
        end else if (f >= s || db == 17'd0) begin
            ex = 1'b1; lat = 1;
        end else begin
            prod = longint'(db) * longint'(s - f);
            if (prod >= 64'd1048576) begin
                ex = 1'b0; lat = 2;
            end else begin
                ex  = real'(r) < p_ref_of(db, longint'(s - f));
                lat = FULL_LAT;
            end
        end
    endfunction

    // Monitor: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_exchange", 32'(out_exchange), 32'(e.exch));
                check("exchange_cmd", 32'(exchange_cmd), 32'(e.cmd));
                check("latency", 32'(cyc - e.start), 32'(e.lat));
                if (e.exch && model_cnt != 65535) model_cnt++;
            end
        end
    end

    // Called right after a negedge; returns one negedge later.
    task automatic pulse_test(input distance_t s, input distance_t f, input logic [16:0] db,
                              input logic [15:0] r, input logic par);
        logic ex;
        int   lat;
        exp_t e;
        expect_of(s, f, db, r, par, ex, lat);
        self_dist  = s;
        folw_dist  = f;
        delta_beta = db;
        rand_val   = r;
        parity     = par;
        test_start = 1'b1;
        e.exch  = ex;
        e.cmd   = ex ? FOLW : SELF;
        e.start = cyc;
        e.lat   = lat;
        sb.push_back(e);
        @(negedge clk);
        test_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_test(input distance_t s, input distance_t f, input logic [16:0] db,
                            input logic [15:0] r, input logic par);
        @(negedge clk);
        pulse_test(s, f, db, r, par);
        wait_idle();
    endtask

    initial begin
        longint     de;
        logic [16:0] db;
        real        p;
        int         tries;
        distance_t  f;

        reset      = 1'b1;
        test_start = 1'b0;
        parity     = 1'b0;
        self_dist  = '0;
        folw_dist  = '0;
        delta_beta = '0;
        rand_val   = '0;
`ifdef EXCHANGE_STAT_EN
        stat_clear = 1'b0;
`endif
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_exchange", 32'(out_exchange), 32'd0);
        check("rst_cmd", 32'(exchange_cmd), 32'(NOP));
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Non-participating (parity mismatch), immediate accepts
        run_test(20'd1000, 20'd1200, 17'h01000, 16'h0000, 1'b1);
        run_test(20'd1000, 20'd1200, 17'h01000, 16'hFFFF, 1'b0);
        run_test(20'd1200, 20'd1000, 17'h00000, 16'hFFFF, 1'b0);

        // Full path, y = 0.5, p ~ 0x9B45
        run_test(20'd1100, 20'd1000, 17'h00148, 16'h9000, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_out_exchange", 32'(out_exchange), 32'd1);
        check("hold_cmd", 32'(exchange_cmd), 32'(FOLW));
        @(negedge clk);
        pulse_test(20'd1100, 20'd1000, 17'h00148, 16'hA000, 1'b0);
        check("busy_in_mul", 32'(busy), 32'd1);
        check("clear_out_exchange", 32'(out_exchange), 32'd0);
        check("clear_cmd", 32'(exchange_cmd), 32'(NOP));
        wait_idle();

        // Saturated: y >= 16, reject even with rand 0
        run_test(20'd25000, 20'd5000, 17'h10000, 16'h0000, 1'b0);

        // Random full-path cases with a margin around the reference p
        for (int i = 0; i < 6; i++) begin
            tries = 0;
            do begin
                db = 17'($urandom_range(1, 16'h3FFF));
                de = longint'($urandom_range(1, 262143 / int'(db)));
                p  = p_ref_of(db, de);
                tries++;
            end while ((p > 60000.0 || p < 2000.0) && tries < 200);
            f = 20'($urandom_range(0, 700000));
            run_test(f + 20'(de), f, db,
                     (i % 2 == 0) ? 16'(int'(p) - 64) : 16'(int'(p) + 64), 1'b0);
        end

        // Back-to-back: new test_start in the done cycle
        @(negedge clk);
        pulse_test(20'd500, 20'd900, 17'h00100, 16'h1234, 1'b0);
        pulse_test(20'd1100, 20'd1000, 17'h00148, 16'hA000, 1'b0);
        wait_idle();

        // test_start ignored while busy, then reset aborts the test
        @(negedge clk);
        pulse_test(20'd1100, 20'd1000, 17'h00148, 16'h9000, 1'b0);
        folw_dist  = 20'd5000;
        test_start = 1'b1;
        @(negedge clk);
        test_start = 1'b0;
        @(negedge clk);
        test_start = 1'b1;
        @(negedge clk);
        test_start = 1'b0;
        check("busy_ignores_start", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        model_cnt = 0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cmd", 32'(exchange_cmd), 32'(NOP));
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);
        run_test(20'd1100, 20'd1000, 17'h00148, 16'h9000, 1'b0);

`ifdef EXCHANGE_STAT_EN
        @(negedge clk);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        model_cnt  = 0;
        run_test(20'd1000, 20'd1200, 17'h01000, 16'h0000, 1'b0);
        run_test(20'd1100, 20'd1000, 17'h00148, 16'h9000, 1'b0);
        run_test(20'd1100, 20'd1000, 17'h00148, 16'hA000, 1'b0);
        run_test(20'd1000, 20'd1000, 17'h01000, 16'h0000, 1'b0);
        run_test(20'd1000, 20'd1200, 17'h01000, 16'h0000, 1'b1);
        check("accept_cnt_3", 32'(accept_cnt), 32'd3);
        check("accept_cnt_model", 32'(accept_cnt), 32'(model_cnt));
        @(negedge clk);
        stat_clear = 1'b1;
        pulse_test(20'd1000, 20'd1200, 17'h01000, 16'h0000, 1'b0);
        stat_clear = 1'b0;
        wait_idle();
        check("clear_beats_inc", 32'(accept_cnt), 32'd0);

        // Saturation: one immediate accept per cycle while test_start is held
        mon_en     = 1'b0;
        @(negedge clk);
        self_dist  = 20'd1000;
        folw_dist  = 20'd1200;
        delta_beta = 17'h01000;
        parity     = 1'b0;
        test_start = 1'b1;
        repeat (65535) @(negedge clk);
        check("accept_cnt_full", 32'(accept_cnt), 32'hFFFF);
        @(negedge clk);
        test_start = 1'b0;
        check("accept_cnt_sat", 32'(accept_cnt), 32'hFFFF);
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
